// File: rtl/dphy_tx_pkg.sv
// Shared types and constants for the D-PHY HS byte-clock transmit sequencer.
// Holds the FSM encoding, the sync byte, the LP line levels and the lane slicing helper.
package dphy_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LPX     = 3'd1,
    ST_PREPARE = 3'd2,
    ST_HS_ZERO = 3'd3,
    ST_SYNC    = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_TRAIL   = 3'd6,
    ST_EXIT    = 3'd7
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  // LP line levels packed as {p, n}.
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  // Number of byte-clock cycles needed to put one 32-bit word on the lanes.
  function automatic int slice_count(input int lanes);
    return 4 / lanes;
  endfunction

endpackage

// File: rtl/dphy_tx_lane_split.sv
// Combinational word-to-lane mapper: slice s puts word byte (s*DATA_LANES + i) on lane i.
// Also reports bit 7 of each lane byte, which is the last bit serialized on that lane.
module dphy_tx_lane_split #(
  parameter int DATA_LANES = 2,
  parameter int SLICE_W    = 1
) (
  input  logic [31:0]              word_i,
  input  logic [SLICE_W-1:0]       slice_i,
  output logic [DATA_LANES*8-1:0]  bytes_o,
  output logic [DATA_LANES-1:0]    last_bit_o
);

  for (genvar i = 0; i < DATA_LANES; i++) begin : g_lane
    logic [4:0] bit_off;
    assign bit_off       = 5'((int'(slice_i) * DATA_LANES + i) * 8);
    assign bytes_o[8*i +: 8] = word_i[bit_off +: 8];
    assign last_bit_o[i] = word_i[bit_off + 5'd7];
  end

endmodule

// File: rtl/dphy_master_byte_tx.sv
// D-PHY HS transmit sequencer in the byte-clock domain: LP-11 -> LP-01 -> LP-00 -> HS-zero
// -> sync -> payload -> trail -> LP-11, with 32-bit words striped across DATA_LANES lanes.
module dphy_master_byte_tx
  import dphy_tx_pkg::*;
#(
  parameter int DATA_LANES   = 2,
  parameter int T_LPX        = 2,
  parameter int T_HS_PREPARE = 2,
  parameter int T_HS_ZERO    = 6,
  parameter int T_HS_TRAIL   = 4,
  parameter int T_HS_EXIT    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [31:0]             data_i,
  input  logic                    valid_i,
  input  logic                    eop_i,
  output logic                    ready_o,
  output logic [DATA_LANES*8-1:0] hs_data_o,
  output logic                    hs_en_o,
  output logic [DATA_LANES-1:0]   lp_p_o,
  output logic [DATA_LANES-1:0]   lp_n_o,
  output logic                    busy_o,
  output logic                    underflow_o,
  output tx_state_e               state_o
);

  localparam int S       = slice_count(DATA_LANES);
  localparam int SLICE_W = (S > 1) ? $clog2(S) : 1;
  localparam int T_MAX1  = (T_LPX > T_HS_PREPARE) ? T_LPX : T_HS_PREPARE;
  localparam int T_MAX2  = (T_HS_ZERO > T_HS_TRAIL) ? T_HS_ZERO : T_HS_TRAIL;
  localparam int T_MAX3  = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
  localparam int T_MAX   = (T_MAX3 > T_HS_EXIT) ? T_MAX3 : T_HS_EXIT;
  localparam int CNT_W   = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LPX   = CNT_W'(T_LPX - 1);
  localparam logic [CNT_W-1:0] CNT_PREP  = CNT_W'(T_HS_PREPARE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(T_HS_ZERO - 1);
  localparam logic [CNT_W-1:0] CNT_TRAIL = CNT_W'(T_HS_TRAIL - 1);
  localparam logic [CNT_W-1:0] CNT_EXIT  = CNT_W'(T_HS_EXIT - 1);

  if (!(DATA_LANES == 1 || DATA_LANES == 2 || DATA_LANES == 4)) begin : g_bad_lanes
    $error("dphy_master_byte_tx: DATA_LANES must be 1, 2 or 4");
  end
  if (T_LPX < 1 || T_HS_PREPARE < 1 || T_HS_ZERO < 1 || T_HS_TRAIL < 1 || T_HS_EXIT < 1)
  begin : g_bad_timing
    $error("dphy_master_byte_tx: every T_* timing parameter must be at least 1");
  end

  tx_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SLICE_W-1:0]     slice_q;
  logic [31:0]            word_q;
  logic                   eop_q;
  logic [DATA_LANES-1:0]  last_bit_q;

  logic                   last_slice;
  logic                   cnt_done;
  logic [31:0]            nxt_word;
  logic [SLICE_W-1:0]     nxt_slice;
  logic [DATA_LANES*8-1:0] split_bytes;
  logic [DATA_LANES-1:0]  split_last;
  logic [DATA_LANES*8-1:0] trail_bytes;

  assign state_o    = state_q;
  assign last_slice = (slice_q == SLICE_W'(S - 1));
  assign cnt_done   = (cnt_q == '0);

  // The splitter always looks one slice ahead so hs_data_o can stay registered.
  assign nxt_slice = (state_q == ST_PAYLOAD && !last_slice) ? slice_q + SLICE_W'(1) : '0;
  assign nxt_word  = (state_q == ST_PAYLOAD && last_slice) ? data_i : word_q;

  dphy_tx_lane_split #(
    .DATA_LANES (DATA_LANES),
    .SLICE_W    (SLICE_W)
  ) u_split (
    .word_i     (nxt_word),
    .slice_i    (nxt_slice),
    .bytes_o    (split_bytes),
    .last_bit_o (split_last)
  );

  for (genvar i = 0; i < DATA_LANES; i++) begin : g_trail
    assign trail_bytes[8*i +: 8] = {8{~last_bit_q[i]}};
  end

  always_comb begin
    ready_o = 1'b0;
    if (!rst_i) begin
      if (state_q == ST_IDLE) ready_o = enable_i;
      else if (state_q == ST_PAYLOAD && last_slice && !eop_q) ready_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      slice_q     <= '0;
      word_q      <= '0;
      eop_q       <= 1'b0;
      last_bit_q  <= '0;
      hs_data_o   <= '0;
      hs_en_o     <= 1'b0;
      lp_p_o      <= '1;
      lp_n_o      <= '1;
      busy_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      underflow_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable_i && valid_i) begin
            word_q  <= data_i;
            eop_q   <= eop_i;
            state_q <= ST_LPX;
            cnt_q   <= CNT_LPX;
            lp_p_o  <= {DATA_LANES{LP01[1]}};
            lp_n_o  <= {DATA_LANES{LP01[0]}};
            busy_o  <= 1'b1;
          end
        end
        ST_LPX: begin
          if (cnt_done) begin
            state_q <= ST_PREPARE;
            cnt_q   <= CNT_PREP;
            lp_p_o  <= {DATA_LANES{LP00[1]}};
            lp_n_o  <= {DATA_LANES{LP00[0]}};
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_PREPARE: begin
          if (cnt_done) begin
            state_q   <= ST_HS_ZERO;
            cnt_q     <= CNT_ZERO;
            hs_en_o   <= 1'b1;
            hs_data_o <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HS_ZERO: begin
          if (cnt_done) begin
            state_q   <= ST_SYNC;
            hs_data_o <= {DATA_LANES{SYNC_BYTE}};
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SYNC: begin
          state_q    <= ST_PAYLOAD;
          slice_q    <= nxt_slice;
          hs_data_o  <= split_bytes;
          last_bit_q <= split_last;
        end
        ST_PAYLOAD: begin
          if (!last_slice) begin
            slice_q    <= nxt_slice;
            hs_data_o  <= split_bytes;
            last_bit_q <= split_last;
          end else if (!eop_q && valid_i) begin
            word_q     <= data_i;
            eop_q      <= eop_i;
            slice_q    <= nxt_slice;
            hs_data_o  <= split_bytes;
            last_bit_q <= split_last;
          end else begin
            // Either a clean end of packet or a starved word boundary; both close the burst.
            underflow_o <= !eop_q;
            state_q     <= ST_TRAIL;
            cnt_q       <= CNT_TRAIL;
            hs_data_o   <= trail_bytes;
          end
        end
        ST_TRAIL: begin
          if (cnt_done) begin
            state_q   <= ST_EXIT;
            cnt_q     <= CNT_EXIT;
            hs_en_o   <= 1'b0;
            hs_data_o <= '0;
            lp_p_o    <= {DATA_LANES{LP11[1]}};
            lp_n_o    <= {DATA_LANES{LP11[0]}};
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_EXIT: begin
          if (cnt_done) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dphy_master_byte_tx.sv
// Bench for dphy_master_byte_tx: 1-, 2- and 4-lane instances driven from one directed
// sequence, every output cycle compared against a trace built from the burst rules.
module tb_dphy_master_byte_tx;
  import dphy_tx_pkg::*;

  localparam int T_LPX   = 2;
  localparam int T_PREP  = 2;
  localparam int T_ZERO  = 6;
  localparam int T_TRAIL = 4;
  localparam int T_EXIT  = 4;

  typedef struct packed {
    logic        p;
    logic        n;
    logic        hs_en;
    logic [31:0] data;
    logic        ready;
    logic        udf;
    logic        busy;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT wiring (index k: 0 -> 1 lane, 1 -> 2 lanes, 2 -> 4 lanes) -------
  logic [2:0]  en, vld, eopv, rdy, hse, bsy, udf;
  logic [31:0] dat [3];
  tx_state_e   st0, st1, st2;
  logic [7:0]  hs1;
  logic [15:0] hs2;
  logic [31:0] hs4;
  logic        lpp1, lpn1;
  logic [1:0]  lpp2, lpn2;
  logic [3:0]  lpp4, lpn4;
  logic [31:0] hsd [3];
  logic [3:0]  lpp [3];
  logic [3:0]  lpn [3];
  tx_state_e   st  [3];

  always_comb begin
    hsd[0] = 32'(hs1);  hsd[1] = 32'(hs2);  hsd[2] = hs4;
    lpp[0] = 4'(lpp1);  lpp[1] = 4'(lpp2);  lpp[2] = lpp4;
    lpn[0] = 4'(lpn1);  lpn[1] = 4'(lpn2);  lpn[2] = lpn4;
    st[0]  = st0;       st[1]  = st1;       st[2]  = st2;
  end

  dphy_master_byte_tx #(.DATA_LANES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .data_i(dat[0]), .valid_i(vld[0]),
    .eop_i(eopv[0]), .ready_o(rdy[0]), .hs_data_o(hs1), .hs_en_o(hse[0]),
    .lp_p_o(lpp1), .lp_n_o(lpn1), .busy_o(bsy[0]), .underflow_o(udf[0]), .state_o(st0));

  dphy_master_byte_tx #(.DATA_LANES(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .data_i(dat[1]), .valid_i(vld[1]),
    .eop_i(eopv[1]), .ready_o(rdy[1]), .hs_data_o(hs2), .hs_en_o(hse[1]),
    .lp_p_o(lpp2), .lp_n_o(lpn2), .busy_o(bsy[1]), .underflow_o(udf[1]), .state_o(st1));

  dphy_master_byte_tx #(.DATA_LANES(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[2]), .data_i(dat[2]), .valid_i(vld[2]),
    .eop_i(eopv[2]), .ready_o(rdy[2]), .hs_data_o(hs4), .hs_en_o(hse[2]),
    .lp_p_o(lpp4), .lp_n_o(lpn4), .busy_o(bsy[2]), .underflow_o(udf[2]), .state_o(st2));

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q [$];
  logic [31:0] pkt_w [$];
  bit          pkt_eop [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int lanes_of(input int k);
    return 1 << k;
  endfunction

  function automatic logic [3:0] lmask(input int k);
    return 4'((1 << lanes_of(k)) - 1);
  endfunction

  function automatic logic [7:0] wbyte(input logic [31:0] w, input int b);
    return 8'(w >> (8 * b));
  endfunction

  function automatic exp_t mk(input logic p, input logic n, input logic hs,
                              input logic [31:0] d, input logic r, input logic u,
                              input logic b);
    exp_t e;
    e.p = p; e.n = n; e.hs_en = hs; e.data = d; e.ready = r; e.udf = u; e.busy = b;
    return e;
  endfunction

  // Reference trace: one entry per cycle after the accepting edge, ending on the IDLE cycle.
  task automatic build_expected(input int k);
    int          nl;
    int          ns;
    int          last;
    logic [31:0] d;
    logic [7:0]  b;
    nl   = lanes_of(k);
    ns   = 4 / nl;
    last = pkt_w.size() - 1;
    exp_q.delete();
    repeat (T_LPX)  exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
    repeat (T_PREP) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
    repeat (T_ZERO) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1));
    d = '0;
    for (int i = 0; i < nl; i++) d |= 32'(SYNC_BYTE) << (8 * i);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b1));
    for (int j = 0; j < pkt_w.size(); j++) begin
      for (int s = 0; s < ns; s++) begin
        d = '0;
        for (int i = 0; i < nl; i++) d |= 32'(wbyte(pkt_w[j], s * nl + i)) << (8 * i);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, d, (s == ns - 1) && !pkt_eop[j], 1'b0, 1'b1));
      end
      if (pkt_eop[j]) begin
        last = j;
        break;
      end
    end
    d = '0;
    for (int i = 0; i < nl; i++) begin
      b = wbyte(pkt_w[last], (ns - 1) * nl + i);
      if (!b[7]) d |= 32'hFF << (8 * i);
    end
    for (int t = 0; t < T_TRAIL; t++)
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, d, 1'b0, (t == 0) && !pkt_eop[last], 1'b1));
    repeat (T_EXIT) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic check_rec(input int k, input exp_t e, input string ph);
    chk({ph, ".lp_p"},  32'(lpp[k]), e.p ? 32'(lmask(k)) : 32'h0);
    chk({ph, ".lp_n"},  32'(lpn[k]), e.n ? 32'(lmask(k)) : 32'h0);
    chk({ph, ".hs_en"}, 32'(hse[k]), 32'(e.hs_en));
    if (e.hs_en) chk({ph, ".hs_data"}, hsd[k], e.data);
    chk({ph, ".ready"}, 32'(rdy[k]), 32'(e.ready));
    chk({ph, ".underflow"}, 32'(udf[k]), 32'(e.udf));
    chk({ph, ".busy"},  32'(bsy[k]), 32'(e.busy));
  endtask

  task automatic make_pkt(input int n, input bit starve);
    pkt_w.delete();
    pkt_eop.delete();
    for (int j = 0; j < n; j++) begin
      pkt_w.push_back($urandom);
      pkt_eop.push_back((j == n - 1) && !starve);
    end
  endtask

  // Driver + checker; called just after a rising edge. cut>0 stops after that many cycles.
  task automatic run_burst(input int k, input int hold, input int cut, input string name);
    int   idx;
    bit   acc;
    int   n_cyc;
    exp_t e;
    build_expected(k);
    idx     = 0;
    dat[k]  = pkt_w[0];
    eopv[k] = pkt_eop[0];
    vld[k]  = 1'b1;
    en[k]   = (hold == 0);
    #1;
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("%s.hold%0d.ready", name, h), 32'(rdy[k]), 32'h0);
      chk($sformatf("%s.hold%0d.lp_p", name, h), 32'(lpp[k]), 32'(lmask(k)));
      chk($sformatf("%s.hold%0d.busy", name, h), 32'(bsy[k]), 32'h0);
      @(posedge clk); #1;
    end
    en[k] = 1'b1;
    #1;
    chk({name, ".idle_ready"}, 32'(rdy[k]), 32'h1);
    acc   = vld[k] && rdy[k];
    n_cyc = (cut > 0) ? cut : exp_q.size();
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < pkt_w.size()) begin
          dat[k]  = pkt_w[idx];
          eopv[k] = pkt_eop[idx];
          vld[k]  = 1'b1;
        end else begin
          vld[k] = 1'b0;
        end
      end
      e = exp_q.pop_front();
      check_rec(k, e, $sformatf("%s.c%0d", name, c));
      acc = vld[k] && rdy[k];
    end
    if (cut == 0) begin
      vld[k] = 1'b0;
      chk({name, ".end_state"}, 32'(st[k]), 32'(ST_IDLE));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst  = 1'b1;
    en   = '1;
    vld  = '0;
    eopv = '0;
    for (int k = 0; k < 3; k++) dat[k] = '0;
    #8;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d.ready", k), 32'(rdy[k]), 32'h0);
      chk($sformatf("rst%0d.hs_en", k), 32'(hse[k]), 32'h0);
      chk($sformatf("rst%0d.lp_p", k),  32'(lpp[k]), 32'(lmask(k)));
      chk($sformatf("rst%0d.lp_n", k),  32'(lpn[k]), 32'(lmask(k)));
      chk($sformatf("rst%0d.busy", k),  32'(bsy[k]), 32'h0);
      chk($sformatf("rst%0d.udf", k),   32'(udf[k]), 32'h0);
    end
    #4 rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idle%0d.state", k), 32'(st[k]), 32'(ST_IDLE));
      chk($sformatf("idle%0d.ready", k), 32'(rdy[k]), 32'h1);
    end

    // 2 lanes, single word with eop
    pkt_w.delete(); pkt_eop.delete();
    pkt_w.push_back(32'h44332211); pkt_eop.push_back(1'b1);
    run_burst(1, 0, 0, "two_lane_single");

    // 4 lanes, three back-to-back words
    make_pkt(3, 1'b0);
    run_burst(2, 0, 0, "four_lane_b2b");

    // 1 lane, two words
    make_pkt(2, 1'b0);
    run_burst(0, 0, 0, "one_lane_two");

    // 2 lanes, source starves after the first word
    make_pkt(1, 1'b1);
    run_burst(1, 0, 0, "underflow");

    // enable held low while data is offered
    make_pkt(1, 1'b0);
    run_burst(1, 4, 0, "enable_gate");

    // reset during the first payload cycle
    make_pkt(2, 1'b0);
    run_burst(1, 0, T_LPX + T_PREP + T_ZERO + 2, "pre_abort");
    #2 rst = 1'b1;
    #1;
    chk("abort.hs_en", 32'(hse[1]), 32'h0);
    chk("abort.lp_p",  32'(lpp[1]), 32'(lmask(1)));
    chk("abort.lp_n",  32'(lpn[1]), 32'(lmask(1)));
    chk("abort.ready", 32'(rdy[1]), 32'h0);
    chk("abort.busy",  32'(bsy[1]), 32'h0);
    chk("abort.state", 32'(st[1]),  32'(ST_IDLE));
    vld[1] = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    make_pkt(2, 1'b0);
    run_burst(1, 0, 0, "after_abort");

    // randomized bursts across lane counts
    for (int r = 0; r < 8; r++) begin
      int  k;
      int  n;
      bit  starve;
      k      = $urandom_range(0, 2);
      n      = $urandom_range(1, 3);
      starve = ($urandom_range(0, 3) == 0);
      make_pkt(n, starve);
      run_burst(k, $urandom_range(0, 2), 0, $sformatf("rand%0d_k%0d", r, k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
